// File: rtl/pipelined_prefix_adder_if.sv
// Handshaked operand/result bundle for the pipelined prefix adder.
// master = producer/consumer side, slave = the adder.
interface pipelined_prefix_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake and a global stall.
// Internal pipeline registers sit before evenly spaced prefix levels; the last stage is the output register.
module pipelined_prefix_adder #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    pipelined_prefix_adder_if.slave bus
);
    localparam int unsigned LEVELS = $clog2(WIDTH);
    localparam int unsigned STAGES = PIPE_STAGES;
    localparam int unsigned W      = WIDTH;

    // A register sits in front of prefix level lvl when some internal boundary j maps onto it.
    function automatic bit is_boundary(input int unsigned lvl);
        bit hit;
        hit = 1'b0;
        for (int unsigned j = 1; j < STAGES; j++) begin
            if ((j * LEVELS) / STAGES == lvl) hit = 1'b1;
        end
        return hit;
    endfunction

    logic             stall;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [WIDTH-1:0] pre_g;
    logic [WIDTH-1:0] pre_p;

    assign stall        = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    // Carry-in is folded into bit 0's generate so the prefix G of bit i is the carry out of bit i.
    always_comb begin
        b_eff    = bus.sub ? ~bus.b : bus.b;
        c0       = bus.sub | bus.cin;
        pre_p    = bus.a ^ b_eff;
        pre_g    = bus.a & b_eff;
        pre_g[0] = pre_g[0] | (pre_p[0] & c0);
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        logic [WIDTH-1:0] g_in, p_in, p0_in;
        logic             c0_in, v_in;
        logic [WIDTH-1:0] g_st, p_st, p0_st;
        logic             c0_st, v_st;
        logic [WIDTH-1:0] g_nx;

        if (k == 0) begin : g_src
            assign g_in  = pre_g;
            assign p_in  = pre_p;
            assign p0_in = pre_p;
            assign c0_in = c0;
            assign v_in  = bus.in_valid;
        end else begin : g_src
            assign g_in  = g_level[k-1].g_nx;
            assign p_in  = g_level[k-1].g_pnext.p_nx;
            assign p0_in = g_level[k-1].p0_st;
            assign c0_in = g_level[k-1].c0_st;
            assign v_in  = g_level[k-1].v_st;
        end

        if (is_boundary(k)) begin : g_reg
            logic [WIDTH-1:0] g_d, g_q, p_d, p_q, p0_d, p0_q;
            logic             c0_d, c0_q, v_d, v_q;

            always_comb begin
                if (stall) begin
                    {g_d, p_d, p0_d, c0_d, v_d} = {g_q, p_q, p0_q, c0_q, v_q};
                end else begin
                    {g_d, p_d, p0_d, c0_d, v_d} = {g_in, p_in, p0_in, c0_in, v_in};
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    g_q  <= '0;
                    p_q  <= '0;
                    p0_q <= '0;
                    c0_q <= 1'b0;
                    v_q  <= 1'b0;
                end else begin
                    g_q  <= g_d;
                    p_q  <= p_d;
                    p0_q <= p0_d;
                    c0_q <= c0_d;
                    v_q  <= v_d;
                end
            end

            assign {g_st, p_st, p0_st, c0_st, v_st} = {g_q, p_q, p0_q, c0_q, v_q};
        end else begin : g_pass
            assign {g_st, p_st, p0_st, c0_st, v_st} = {g_in, p_in, p0_in, c0_in, v_in};
        end

        localparam int unsigned DIST = 32'd1 << k;

        always_comb begin
            g_nx = g_st;
            for (int unsigned i = DIST; i < W; i++) begin
                g_nx[i] = g_st[i] | (p_st[i] & g_st[i - DIST]);
            end
        end

        // Group propagate is not needed past the final level.
        if (k + 1 < LEVELS) begin : g_pnext
            logic [WIDTH-1:0] p_nx;
            always_comb begin
                p_nx = p_st;
                for (int unsigned i = DIST; i < W; i++) begin
                    p_nx[i] = p_st[i] & p_st[i - DIST];
                end
            end
        end
    end

    logic [WIDTH-1:0] fin_g, fin_p0, carry, res_sum;
    logic             fin_c0, fin_v, res_cout, res_ovf;

    assign fin_g  = g_level[LEVELS-1].g_nx;
    assign fin_p0 = g_level[LEVELS-1].p0_st;
    assign fin_c0 = g_level[LEVELS-1].c0_st;
    assign fin_v  = g_level[LEVELS-1].v_st;

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q, ovf_d, ovf_q, zero_d, zero_q;
    logic             out_valid_d, out_valid_q;

    always_comb begin
        carry    = {fin_g[WIDTH-2:0], fin_c0};
        res_sum  = fin_p0 ^ carry;
        res_cout = fin_g[WIDTH-1];
        res_ovf  = carry[WIDTH-1] ^ res_cout;

        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        if (!stall) begin
            sum_d       = res_sum;
            cout_d      = res_cout;
            ovf_d       = res_ovf;
            zero_d      = ~|res_sum;
            out_valid_d = fin_v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = out_valid_q;
endmodule
